// File: rtl/ay_bus_ctl.sv
// ---------------------------------------------------------------------------
// ay_bus_ctl -- AY-3-8910 PSG bus cycle sequencer with two-way round-robin
// arbitration between the CPU I/O port (requester 0) and the music player
// engine (requester 1).
//
// A granted transaction runs LATCH -> GAP -> WR/RD -> DONE.  Each phase is
// timed in ay_tick pulses (one-clk strobe from the prescaler, ~1.79 MHz):
// LATCH/WR/RD last HOLD_TICKS ticks and GAP lasts GAP_TICKS ticks.
//
// Optional build macro: AY_SHADOW_EN
//   Defined   : a 16x8 shadow copy of the PSG registers is kept.  Writes still
//               run a full bus cycle and refresh the shadow.  Reads are answered
//               from the shadow in one clk without touching the bus.
//   Undefined : no shadow storage; every read runs a full bus cycle.
//
// Ports
//   clk                  system clock (25 MHz)
//   reset                asynchronous active-low reset
//   ay_tick              one-clk phase timing strobe
//   req0/we0/addr0/wdata0  requester 0 request, direction, register, data
//   done0                requester 0 one-clk completion pulse
//   req1/we1/addr1/wdata1/done1  same for requester 1
//   rdata                last read result, valid from its done pulse onward
//   ay_bdir, ay_bc1      PSG bus control (00 idle, 11 latch, 10 write, 01 read)
//   ay_da_out, ay_da_oe  DA bus drive value and output enable
//   ay_da_in             DA bus sampled value
// ---------------------------------------------------------------------------
module ay_bus_ctl #(
    parameter int HOLD_TICKS = 2,
    parameter int GAP_TICKS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ay_tick,
    input  logic       req0,
    input  logic       we0,
    input  logic [3:0] addr0,
    input  logic [7:0] wdata0,
    output logic       done0,
    input  logic       req1,
    input  logic       we1,
    input  logic [3:0] addr1,
    input  logic [7:0] wdata1,
    output logic       done1,
    output logic [7:0] rdata,
    output logic       ay_bdir,
    output logic       ay_bc1,
    output logic [7:0] ay_da_out,
    output logic       ay_da_oe,
    input  logic [7:0] ay_da_in
);

    localparam int MAX_T = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int CNT_W = $clog2(MAX_T + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

`ifdef AY_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_GAP,
        S_WR,
        S_RD,
        S_DONE
    } state_t;

    state_t           state;
    logic             gnt;        // requester owning the current transaction
    logic             last_gnt;   // round-robin pointer: most recent winner
    logic [CNT_W-1:0] cnt;
    logic             we_r;
    logic [3:0]       addr_r;
    logic [7:0]       wdata_r;

    logic             any_req;
    logic             gnt_sel;
    logic             sel_we;
    logic [3:0]       sel_addr;
    logic [7:0]       sel_wdata;
    logic [CNT_W-1:0] cnt_inc;
    logic             tick_term;
    logic [7:0]       shadow_q;

    // Arbitration: a lone requester wins outright; on contention the one
    // that did not win last time goes first.
    always_comb begin
        any_req   = req0 | req1;
        gnt_sel   = (req0 && req1) ? ~last_gnt : req1;
        sel_we    = gnt_sel ? we1    : we0;
        sel_addr  = gnt_sel ? addr1  : addr0;
        sel_wdata = gnt_sel ? wdata1 : wdata0;
    end

    // Terminal tick of the current phase.  The counter saturates rather than
    // wrapping, although the phase always ends before it could.
    always_comb begin
        cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
        tick_term = 1'b0;
        case (state)
            S_LATCH, S_WR, S_RD: tick_term = ay_tick && (cnt == HOLD_LAST);
            S_GAP:               tick_term = ay_tick && (cnt == GAP_LAST);
            default:             tick_term = 1'b0;
        endcase
    end

`ifdef AY_SHADOW_EN
    logic [7:0] shadow [16];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                shadow[i] <= 8'h00;
            end
        end else if (state == S_WR && tick_term) begin
            shadow[addr_r] <= wdata_r;
        end
    end

    assign shadow_q = shadow[sel_addr];
`else
    assign shadow_q = 8'h00;
`endif

    // Winner's request fields, captured on the grant edge and held for the
    // whole transaction so the requester may change its inputs afterwards.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && any_req) begin
            we_r    <= sel_we;
            addr_r  <= sel_addr;
            wdata_r <= sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;    // so requester 0 wins the first contention
            cnt       <= '0;
            ay_bdir   <= 1'b0;
            ay_bc1    <= 1'b0;
            ay_da_oe  <= 1'b0;
            ay_da_out <= 8'h00;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata     <= 8'h00;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (ay_tick && !tick_term && state != S_IDLE && state != S_DONE) begin
                cnt <= cnt_inc;
            end
            case (state)
                S_IDLE: begin
                    // Ticks on the grant edge are deliberately not counted.
                    if (any_req) begin
                        gnt      <= gnt_sel;
                        last_gnt <= gnt_sel;
                        cnt      <= '0;
                        if (SHADOW && !sel_we) begin
                            state <= S_DONE;
                            rdata <= shadow_q;
                            done0 <= ~gnt_sel;
                            done1 <= gnt_sel;
                        end else begin
                            state     <= S_LATCH;
                            ay_bdir   <= 1'b1;
                            ay_bc1    <= 1'b1;
                            ay_da_oe  <= 1'b1;
                            ay_da_out <= {4'b0000, sel_addr};
                        end
                    end
                end
                S_LATCH: begin
                    if (tick_term) begin
                        state   <= S_GAP;
                        cnt     <= '0;
                        ay_bdir <= 1'b0;
                        ay_bc1  <= 1'b0;
                    end
                end
                S_GAP: begin
                    // Address stays on DA through the gap.
                    if (tick_term) begin
                        cnt <= '0;
                        if (we_r) begin
                            state     <= S_WR;
                            ay_bdir   <= 1'b1;
                            ay_da_out <= wdata_r;
                        end else begin
                            state    <= S_RD;
                            ay_bc1   <= 1'b1;
                            ay_da_oe <= 1'b0;
                        end
                    end
                end
                S_WR: begin
                    if (tick_term) begin
                        state    <= S_DONE;
                        cnt      <= '0;
                        ay_bdir  <= 1'b0;
                        ay_da_oe <= 1'b0;
                        done0    <= ~gnt;
                        done1    <= gnt;
                    end
                end
                S_RD: begin
                    // Sample DA on the same edge that drops BC1, so the PSG
                    // is still driving the bus.
                    if (tick_term) begin
                        state  <= S_DONE;
                        cnt    <= '0;
                        ay_bc1 <= 1'b0;
                        rdata  <= ay_da_in;
                        done0  <= ~gnt;
                        done1  <= gnt;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
